// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encodings, blink masks and debounce default shared by the stopwatch control blocks
package stopwatch_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;
  localparam logic [1:0] BLINK_NONE = 2'b00;
  localparam logic [1:0] BLINK_MIN  = 2'b10;
  localparam logic [1:0] BLINK_SEC  = 2'b01;
  localparam int DEB_CNT_DEF = 50000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter, debounced level and one-cycle press pulse
module btn_debounce #(
  parameter int DEB_CNT = 50000,
  parameter int DEB_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_press
);
  logic [1:0]       r_sync;
  logic [DEB_W-1:0] r_cnt;
  logic             r_lvl;
  logic             r_press;
  // level flips once the synced value has disagreed for DEB_CNT+1 samples; rising flip emits the press
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_press <= 1'b0;
      if (r_sync[1] == r_lvl) r_cnt <= '0;
      else if (r_cnt == DEB_W'(DEB_CNT)) begin
        r_lvl   <= ~r_lvl;
        r_cnt   <= '0;
        r_press <= ~r_lvl;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_press = r_press;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: RUN/PAUSE/ADJ sequencer issuing count, adjust and clear strobes plus the blink mask.
// Optional macro STOPWATCH_BLINK_EN enables the ADJ-mode field blink phase.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEF,
  parameter int DEB_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       but_pause,
  input  logic       but_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic       cnt_inc,
  output logic       adj_min,
  output logic       adj_sec,
  output logic       cnt_clr,
  output logic [1:0] blink_mask,
  output logic [1:0] state_o
);
  logic       w_pause_press, w_clear_press, w_adj, w_sel, w_stay_adj;
  logic       w_inc, w_amin, w_asec, w_clr;
  logic [1:0] r_adj_s, r_sel_s;
  logic       r_ret_run, r_rdy;
  logic       r_inc, r_amin, r_asec, r_clr;
  state_t     r_state, w_next;

  btn_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_pause (
    .clk(clk), .rst(rst), .i_raw(but_pause), .o_press(w_pause_press)
  );
  btn_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_clear (
    .clk(clk), .rst(rst), .i_raw(but_clear), .o_press(w_clear_press)
  );

  assign w_adj = r_adj_s[1];
  assign w_sel = r_sel_s[1];

  // switch synchronizers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_adj_s <= 2'b00;
      r_sel_s <= 2'b00;
    end else begin
      r_adj_s <= {r_adj_s[0], sw_adj};
      r_sel_s <= {r_sel_s[0], sw_sel};
    end
  end

  // state register; ret_run remembers where ADJ was entered from, r_rdy masks the first edge after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_ret_run <= 1'b1;
      r_rdy     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= 1'b1;
      if (w_next == ST_ADJ && r_state != ST_ADJ) r_ret_run <= (r_state == ST_RUN);
    end
  end

  // next state: ADJ overrides a coincident pause press, which is then dropped
  always_comb begin
    w_next = ST_RUN;
    case (r_state)
      ST_RUN:   w_next = w_adj ? ST_ADJ : (w_pause_press ? ST_PAUSE : ST_RUN);
      ST_PAUSE: w_next = w_adj ? ST_ADJ : (w_pause_press ? ST_RUN : ST_PAUSE);
      ST_ADJ:   w_next = w_adj ? ST_ADJ : (r_ret_run ? ST_RUN : ST_PAUSE);
      default:  w_next = ST_RUN;
    endcase
  end

  // strobe decode: clear wins, and count/adjust only fire when not crossing into or out of ADJ
  always_comb begin
    w_stay_adj = (r_state == ST_ADJ) && (w_next == ST_ADJ);
    w_clr      = r_rdy & w_clear_press;
    w_inc      = r_rdy & ~w_clear_press & tick_1hz & (r_state == ST_RUN) & (w_next != ST_ADJ);
    w_amin     = r_rdy & ~w_clear_press & tick_2hz & w_stay_adj & ~w_sel;
    w_asec     = r_rdy & ~w_clear_press & tick_2hz & w_stay_adj & w_sel;
  end

  // registered strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inc  <= 1'b0;
      r_amin <= 1'b0;
      r_asec <= 1'b0;
      r_clr  <= 1'b0;
    end else begin
      r_inc  <= w_inc;
      r_amin <= w_amin;
      r_asec <= w_asec;
      r_clr  <= w_clr;
    end
  end

  assign cnt_inc = r_inc;
  assign adj_min = r_amin;
  assign adj_sec = r_asec;
  assign cnt_clr = r_clr;
  assign state_o = r_state;

`ifdef STOPWATCH_BLINK_EN
  logic r_phase;
  // blink phase held clear outside ADJ so the selected field shows first after entry
  always_ff @(posedge clk) begin
    if (!rst || r_state != ST_ADJ) r_phase <= 1'b0;
    else if (tick_2hz) r_phase <= ~r_phase;
  end
  assign blink_mask = (r_state == ST_ADJ && r_phase) ? (w_sel ? BLINK_SEC : BLINK_MIN) : BLINK_NONE;
`else
  assign blink_mask = BLINK_NONE;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table vectors, directed corner sequences and random stimulus against a reference model
module tb_stopwatch_ctrl;
  localparam int DC = 4;
  localparam int H  = DC + 3;

  logic clk = 0, rst = 0, tick_1hz = 0, tick_2hz = 0;
  logic but_pause = 0, but_clear = 0, sw_adj = 0, sw_sel = 0;
  logic cnt_inc, adj_min, adj_sec, cnt_clr;
  logic [1:0] blink_mask, state_o;
  int total = 0, bad = 0;

  stopwatch_ctrl #(.DEB_CNT(DC), .DEB_W(16)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .but_pause(but_pause), .but_clear(but_clear), .sw_adj(sw_adj), .sw_sel(sw_sel),
    .cnt_inc(cnt_inc), .adj_min(adj_min), .adj_sec(adj_sec), .cnt_clr(cnt_clr),
    .blink_mask(blink_mask), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // reference model: raw input histories (index j = value applied j edges ago)
  bit ph[H], ch[H], ah[H], sh[H];
  bit m_plvl, m_clvl, m_pp, m_cp, m_ret, m_rdy, m_phase;
  bit m_inc, m_amin, m_asec, m_clr;
  logic [1:0] m_st;

  // a debounced level flips when the last DC+1 synchronized samples all disagree with it
  function automatic bit flips(input bit h[H], input bit lvl);
    for (int j = 2; j < H; j++) if (h[j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] m_blink();
`ifdef STOPWATCH_BLINK_EN
    return (m_st == 2'd2 && m_phase) ? (sh[1] ? 2'b01 : 2'b10) : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  task automatic model_edge();
    logic [1:0] ns;
    bit pf, cf;
    if (!rst) begin
      for (int j = 0; j < H; j++) begin ph[j] = 0; ch[j] = 0; ah[j] = 0; sh[j] = 0; end
      m_plvl = 0; m_clvl = 0; m_pp = 0; m_cp = 0; m_ret = 1; m_rdy = 0; m_phase = 0;
      m_inc = 0; m_amin = 0; m_asec = 0; m_clr = 0; m_st = 2'd0;
    end else begin
      for (int j = H - 1; j > 0; j--) begin ph[j] = ph[j-1]; ch[j] = ch[j-1]; ah[j] = ah[j-1]; sh[j] = sh[j-1]; end
      ph[0] = but_pause; ch[0] = but_clear; ah[0] = sw_adj; sh[0] = sw_sel;
      ns = m_st;
      if (m_st == 2'd2) ns = ah[2] ? 2'd2 : (m_ret ? 2'd0 : 2'd1);
      else if (m_st == 2'd3) ns = 2'd0;
      else if (ah[2]) begin ns = 2'd2; m_ret = (m_st == 2'd0); end
      else if (m_pp) ns = (m_st == 2'd0) ? 2'd1 : 2'd0;
      m_clr  = m_rdy && m_cp;
      m_inc  = m_rdy && !m_cp && tick_1hz && m_st == 2'd0 && ns != 2'd2;
      m_asec = m_rdy && !m_cp && tick_2hz && m_st == 2'd2 && ns == 2'd2 && sh[2];
      m_amin = m_rdy && !m_cp && tick_2hz && m_st == 2'd2 && ns == 2'd2 && !sh[2];
      m_phase = (m_st == 2'd2) ? (m_phase ^ tick_2hz) : 1'b0;
      pf = flips(ph, m_plvl);
      cf = flips(ch, m_clvl);
      m_pp = pf && !m_plvl;
      m_cp = cf && !m_clvl;
      if (pf) m_plvl = !m_plvl;
      if (cf) m_clvl = !m_clvl;
      m_st = ns;
      m_rdy = 1;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // one clock edge: advance the model, then compare every output away from the edge
  task automatic step();
    logic [7:0] got, exp;
    @(posedge clk);
    model_edge();
    #1;
    got = {cnt_inc, adj_min, adj_sec, cnt_clr, state_o, blink_mask};
    exp = {m_inc, m_amin, m_asec, m_clr, m_st, m_blink()};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL model got=%b exp=%b t=%0t", got, exp, $time);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic r, t1, t2, bp, bc, adj, sel;
    logic [3:0] strb;
    logic [1:0] st;
  } vec_t;
  vec_t tv[20];

  initial begin
    int n, cnt, hp, hc, ha;
    tv[0]  = '{0,0,0,0,0,0,0, 4'b0000, 2'd0};
    tv[1]  = '{0,0,0,0,0,0,0, 4'b0000, 2'd0};
    tv[2]  = '{1,0,0,0,0,0,0, 4'b0000, 2'd0};
    tv[3]  = '{1,1,0,0,0,0,0, 4'b1000, 2'd0};
    tv[4]  = '{1,0,0,0,0,0,0, 4'b0000, 2'd0};
    tv[5]  = '{1,1,0,0,0,0,0, 4'b1000, 2'd0};
    tv[6]  = '{1,0,0,0,0,0,0, 4'b0000, 2'd0};
    tv[7]  = '{1,1,0,0,0,0,0, 4'b1000, 2'd0};
    tv[8]  = '{1,0,0,0,0,0,0, 4'b0000, 2'd0};
    tv[9]  = '{1,0,0,0,0,1,1, 4'b0000, 2'd0};
    tv[10] = '{1,0,0,0,0,1,1, 4'b0000, 2'd0};
    tv[11] = '{1,0,0,0,0,1,1, 4'b0000, 2'd2};
    tv[12] = '{1,0,1,0,0,1,1, 4'b0010, 2'd2};
    tv[13] = '{1,1,0,0,0,1,1, 4'b0000, 2'd2};
    tv[14] = '{1,0,1,0,0,1,1, 4'b0010, 2'd2};
    tv[15] = '{1,0,0,0,0,1,1, 4'b0000, 2'd2};
    tv[16] = '{1,0,0,0,0,0,1, 4'b0000, 2'd2};
    tv[17] = '{1,0,0,0,0,0,1, 4'b0000, 2'd2};
    tv[18] = '{1,0,0,0,0,0,1, 4'b0000, 2'd0};
    tv[19] = '{1,1,0,0,0,0,1, 4'b1000, 2'd0};
    for (int i = 0; i < 20; i++) begin
      rst = tv[i].r; tick_1hz = tv[i].t1; tick_2hz = tv[i].t2; but_pause = tv[i].bp;
      but_clear = tv[i].bc; sw_adj = tv[i].adj; sw_sel = tv[i].sel;
      step();
      check($sformatf("vec%0d", i), int'({cnt_inc, adj_min, adj_sec, cnt_clr, state_o}), int'({tv[i].strb, tv[i].st}));
    end
    tick_1hz = 0;

    // clean pause press: debounced press after DC+3 edges, state changes on the next edge
    but_pause = 1;
    steps(DC + 3);
    check("pause_pre", int'(state_o), 0);
    step();
    check("pause_on", int'(state_o), 1);
    tick_1hz = 1; step(); tick_1hz = 0;
    check("pause_noinc", int'(cnt_inc), 0);
    but_pause = 0; steps(10);
    check("release_nop", int'(state_o), 1);
    but_pause = 1; n = 0;
    do begin step(); n++; end while (state_o != 2'd0 && n < 20);
    check("resume_lat", n, DC + 4);
    but_pause = 0; steps(10);

    // glitch shorter than DC cycles is ignored
    but_pause = 1; steps(3); but_pause = 0; steps(15);
    check("glitch", int'(state_o), 0);

    // ADJ from PAUSE, seconds field
    but_pause = 1; steps(DC + 4); but_pause = 0; steps(10);
    check("adj_from_pause", int'(state_o), 1);
    sw_adj = 1; sw_sel = 1; steps(3);
    check("adj_enter", int'(state_o), 2);
    check("adj_blink0", int'(blink_mask), 0);
    cnt = 0;
    for (int k = 0; k < 2; k++) begin
      tick_2hz = 1; step(); tick_2hz = 0;
      cnt += int'(adj_sec);
`ifdef STOPWATCH_BLINK_EN
      check("adj_blink", int'(blink_mask), k == 0 ? 1 : 0);
`endif
      step();
    end
    check("adj_sec_cnt", cnt, 2);
    sw_adj = 0; steps(3);
    check("adj_exit", int'(state_o), 1);

    // clear press coincident with a count tick in RUN
    but_pause = 1; steps(DC + 4); but_pause = 0; steps(10);
    check("back_run", int'(state_o), 0);
    but_clear = 1; steps(DC + 3);
    tick_1hz = 1; step(); tick_1hz = 0;
    check("clr_strobe", int'(cnt_clr), 1);
    check("clr_prio", int'(cnt_inc), 0);
    check("clr_state", int'(state_o), 0);
    but_clear = 0; steps(10);

    // reset mid-debounce while in ADJ
    sw_adj = 1; steps(3);
    check("adj_again", int'(state_o), 2);
    but_pause = 1; steps(3);
    rst = 0; sw_adj = 0; but_pause = 0; step();
    check("rst_state", int'(state_o), 0);
    check("rst_out", int'({cnt_inc, adj_min, adj_sec, cnt_clr, blink_mask}), 0);
    rst = 1; tick_1hz = 1; step(); tick_1hz = 0;
    check("rst_nostrobe", int'(cnt_inc), 0);
    steps(15);
    check("rst_nopress", int'(state_o), 0);

    // randomized stimulus against the model
    hp = 0; hc = 0; ha = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) != 0);
      tick_1hz = !tick_1hz && ($urandom_range(0, 5) == 0);
      tick_2hz = !tick_2hz && ($urandom_range(0, 3) == 0);
      if (hp == 0) begin but_pause = ~but_pause; hp = $urandom_range(1, 12); end else hp--;
      if (hc == 0) begin but_clear = ~but_clear; hc = $urandom_range(1, 20); end else hc--;
      if (ha == 0) begin sw_adj = ~sw_adj; ha = $urandom_range(5, 80); end else ha--;
      if ($urandom_range(0, 15) == 0) sw_sel = ~sw_sel;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
